// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready command in, SETUP/ACCESS on APB,
// valid/ready response out, with an optional wait-state timeout.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL high for exactly one cycle
// ACCESS | PSEL+PENABLE high, waiting on PREADY or timeout
// RESP   | rsp_valid high until the consumer takes it
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int               CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int               TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);
    localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_pwrite;
    logic                  r_psel;
    logic                  r_penable;

    logic w_cmd_fire;
    logic w_timeout;

    assign w_cmd_fire = r_cmd_ready & cmd_valid;
    assign w_timeout  = TO_EN && (r_wait_cnt == TO_LAST);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        r_paddr <= cmd_addr & ADDR_MASK;
                        if (cmd_write) begin
                            r_pwdata <= cmd_wdata;
                        end
                        r_pwrite    <= cmd_write;
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY wins over expiry on the same edge
                    if (PREADY) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PWRITE      = r_pwrite;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: vector table plus scoreboard queue of expected
// responses, and hand sequences for backpressure, reset abort and no-timeout mode.
module tb_apb_master_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    logic        cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, rsp_err2, rsp_timeout2, busy2;
    logic [31:0] rsp_rdata2, PADDR2, PWDATA2;
    logic        PWRITE2, PSEL2, PENABLE2, PREADY2;

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nt (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
        .rsp_err(rsp_err2), .rsp_timeout(rsp_timeout2), .busy(busy2),
        .PADDR(PADDR2), .PWDATA(PWDATA2), .PWRITE(PWRITE2), .PSEL(PSEL2),
        .PENABLE(PENABLE2), .PRDATA(PRDATA), .PREADY(PREADY2), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        pslverr;
        int          bp;
        bit          chain;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    localparam int NVEC = 7;
    vec_t        tbl[NVEC];
    rsp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rsp_seen = 0;
    logic [31:0] last_wdata;

    always @(negedge HCLK) begin
        if (rsp_valid) rsp_seen <= rsp_seen + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        rsp_t e;
        int   n;
        int   acc;
        int   exp_acc;
        logic [31:0] exp_paddr;
        v = tbl[i];
        exp_paddr = v.addr & 32'hFFFF_FFFC;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_write = v.write;
        sb_q.push_back('{v.exp_rdata, v.exp_err, v.exp_to});
        if (v.write) last_wdata = v.wdata;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);
        chk("setup_ctrl", {PSEL, PENABLE, cmd_ready, busy}, 4'b1001);
        chk("setup_paddr", PADDR, exp_paddr);
        chk("setup_pwrite", PWRITE, v.write);
        chk("setup_pwdata", PWDATA, last_wdata);
        @(posedge HCLK); #1;
        PRDATA  = v.prdata;
        PSLVERR = v.pslverr;
        exp_acc = v.exp_to ? 4 : v.waits + 1;
        acc = 0;
        while (PSEL && PENABLE && acc < 50) begin
            acc++;
            chk("access_hold", {PADDR, PWDATA, 31'd0, PWRITE}, {exp_paddr, last_wdata, 31'd0, v.write});
            PREADY = (acc > v.waits);
            @(posedge HCLK); #1;
            PREADY = 1'b0;
        end
        PSLVERR = 1'b0;
        PRDATA  = $urandom;
        chk("access_len", acc, exp_acc);
        chk("resp_ctrl", {rsp_valid, PSEL, PENABLE, busy, cmd_ready}, 5'b10010);
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        rsp_ready = 1'b0;
        for (int k = 0; k < v.bp; k++) begin
            if (v.chain && i + 1 < NVEC) begin
                cmd_valid = 1'b1;
                cmd_addr  = tbl[i+1].addr;
                cmd_wdata = tbl[i+1].wdata;
                cmd_write = tbl[i+1].write;
            end
            chk("bp_hold", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {1'b1, e.err, e.to, e.rdata});
            chk("bp_no_accept", {cmd_ready, PSEL}, 2'b00);
            @(posedge HCLK); #1;
        end
        rsp_ready = 1'b1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.to);
        @(posedge HCLK); #1;
        rsp_ready = 1'b0;
        chk("rsp_done", {rsp_valid, busy, cmd_ready, PSEL}, 4'b0010);
    endtask

    initial begin
        int n;
        int n_acc;
        int n_rv;
        int snap;

        tbl[0] = '{1'b1, 32'h1A10_3104, 32'hDEAD_BEEF, 0,  32'h5555_5555, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h1A10_3000, 32'h0000_0000, 3,  32'h0000_000A, 1'b0, 0, 1'b0, 32'h0000_000A, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h1A10_3007, 32'h1111_1111, 0,  32'h1234_5678, 1'b1, 0, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 32'h1A10_3010, 32'h2222_2222, 99, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 32'h0000_00FE, 32'h0BAD_F00D, 1,  32'h3333_3333, 1'b1, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 32'h4000_0020, 32'h4444_4444, 2,  32'hCAFE_0001, 1'b0, 5, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 0,  32'h6666_6666, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

        HRESETn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = 32'h0;
        cmd_wdata  = 32'h0;
        cmd_write  = 1'b0;
        rsp_ready  = 1'b0;
        PRDATA     = 32'h0;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
        cmd_valid2 = 1'b0;
        rsp_ready2 = 1'b0;
        PREADY2    = 1'b0;
        last_wdata = 32'h0;

        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_ctrl", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, PWRITE, PSEL, PENABLE}, 8'h00);
        chk("reset_paddr", PADDR, 0);
        chk("reset_pwdata", PWDATA, 0);
        chk("reset_rdata", rsp_rdata, 0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk("post_reset_ready", {cmd_ready, busy}, 2'b10);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // reset in the middle of an ACCESS phase
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge HCLK); #1;
            n++;
        end
        snap      = rsp_seen;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h2000_0010;
        cmd_wdata = 32'h7777_7777;
        cmd_write = 1'b1;
        PREADY    = 1'b0;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        @(posedge HCLK); #1;
        chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        PREADY  = 1'b1;
        chk("abort_ctrl", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, PWRITE, PSEL, PENABLE}, 8'h00);
        chk("abort_paddr", PADDR, 0);
        chk("abort_pwdata", PWDATA, 0);
        repeat (6) @(posedge HCLK);
        #1;
        PREADY = 1'b0;
        chk("abort_no_rsp", rsp_seen, snap);
        chk("abort_idle", {cmd_ready, busy, PSEL}, 3'b100);
        last_wdata = 32'h0;
        run_vec(0);

        // timeout disabled: 1000 wait states must not abort
        cmd_valid2 = 1'b1;
        cmd_addr   = 32'h1A10_3008;
        cmd_write  = 1'b0;
        n = 0;
        while (cmd_ready2 !== 1'b1 && n < 20) begin
            @(posedge HCLK); #1;
            n++;
        end
        @(posedge HCLK); #1;
        cmd_valid2 = 1'b0;
        chk("nt_setup", {PSEL2, PENABLE2}, 2'b10);
        @(posedge HCLK); #1;
        n_acc = 0;
        n_rv  = 0;
        for (int k = 0; k < 1000; k++) begin
            if (PSEL2 && PENABLE2) n_acc++;
            if (rsp_valid2) n_rv++;
            @(posedge HCLK); #1;
        end
        chk("nt_access_cycles", n_acc, 1000);
        chk("nt_no_rsp", n_rv, 0);
        PREADY2 = 1'b1;
        PRDATA  = 32'h600D_F00D;
        @(posedge HCLK); #1;
        PREADY2 = 1'b0;
        chk("nt_rsp", {rsp_valid2, rsp_err2, rsp_timeout2, PSEL2}, 4'b1000);
        chk("nt_rdata", rsp_rdata2, 32'h600D_F00D);
        rsp_ready2 = 1'b1;
        @(posedge HCLK); #1;
        rsp_ready2 = 1'b0;
        chk("nt_done", {rsp_valid2, cmd_ready2}, 2'b01);

        chk("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB3 initiator that turns a valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response stream.
- Sits between a local controller (core-side sequencer, test DMA) and the APB peripheral bus that our APB slaves, such as the MMU register wrapper, hang off.
- Bounds slave wait states with a programmable timeout.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR
- DATA_WIDTH, 32, width of the data paths
- TIMEOUT_CYCLES, 256, maximum number of ACCESS cycles before abort; 0 disables the timeout

Ports:
- HCLK  in  1  clock; all logic is on the rising edge
- HRESETn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_write  in  1  1 = write, 0 = read
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
- rsp_err  out  1  PSLVERR sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  high in any state other than IDLE
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset (HRESETn low at a rising edge):
  - State goes to IDLE.
  - All outputs are 0, including cmd_ready, PADDR and PWDATA.
  - The wait counter is cleared.
  - Reset asserted mid-transfer aborts immediately: PSEL/PENABLE are 0 from the next edge, and no response is produced for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1; PSEL = PENABLE = 0.
  - On cmd_valid & cmd_ready, register PADDR = {cmd_addr[ADDR_WIDTH-1:2], 2'b00}, PWDATA = cmd_wdata (writes only; unchanged on reads) and PWRITE = cmd_write, then go to SETUP.
  - Low address bits are always driven as 0.
- SETUP:
  - PSEL = 1, PENABLE = 0, cmd_ready = 0.
  - Lasts exactly one cycle, then ACCESS; clear the wait counter.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWDATA and PWRITE are held stable.
  - At each edge with PREADY = 1, capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR and rsp_timeout = 0, then go to RESP.
  - If PREADY = 0, increment the wait counter.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 with PREADY still 0, capture rsp_rdata = 0, rsp_err = 1 and rsp_timeout = 1, then go to RESP.
  - PREADY = 1 on the same edge as counter expiry counts as normal completion.
- RESP:
  - PSEL = PENABLE = 0; rsp_valid = 1.
  - rsp_* are held stable until rsp_valid & rsp_ready, then go to IDLE.
  - No new command is accepted in RESP. A command held on cmd_valid is accepted in the following IDLE cycle.
- Latency, with zero wait states and rsp_ready tied high:
  - Command handshake at edge N.
  - SETUP visible in cycle N+1, ACCESS in cycle N+2.
  - rsp_valid in cycle N+3; cmd_ready high again in cycle N+4.
  - Throughput is one transfer per 4 cycles. Each PREADY wait state adds 1 cycle.
- Between transfers PADDR, PWDATA and PWRITE keep their last values; this is an allowed APB idle state.
- The wait counter is wide enough to hold TIMEOUT_CYCLES - 1, with a minimum width of 1 bit.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Test Plan:
- Write, zero wait: cmd_addr = 0x1A10_3104, cmd_wdata = 0xDEADBEEF, cmd_write = 1 at edge N.
  - Cycle N+1: PSEL = 1, PENABLE = 0, PADDR = 0x1A10_3104, PWDATA = 0xDEADBEEF.
  - Cycle N+2: PENABLE = 1.
  - Cycle N+3: rsp_valid = 1, rsp_rdata = 0, rsp_err = 0.
- Read with 3 wait states: cmd_addr = 0x1A10_3000, read; PREADY low for 3 ACCESS cycles, then PRDATA = 0x0000_000A.
  - ACCESS lasts 4 cycles.
  - rsp_rdata = 0xA, appearing 3 cycles later than the zero-wait case.
  - PADDR stays stable throughout.
- Slave error: read with PSLVERR = 1 and PREADY = 1 in ACCESS -> rsp_err = 1, rsp_timeout = 0.
- Timeout: TIMEOUT_CYCLES = 4, PREADY held 0.
  - After 4 ACCESS cycles PSEL drops.
  - rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Repeat with TIMEOUT_CYCLES = 0 and PREADY low for 1000 cycles: no abort occurs.
- Response backpressure: rsp_ready = 0 for 5 cycles while cmd_valid is held with a second command.
  - rsp_* stay stable and cmd_ready stays 0.
  - After rsp_ready = 1, the second command is accepted one cycle later.
- Reset during ACCESS: HRESETn low for one edge while PSEL = 1.
  - Next cycle all outputs are 0 and state is IDLE.
  - rsp_valid never pulses for the aborted command.
